// File: rtl/avalon_pio_ext.sv
// Avalon-MM PIO slave: output reg with set/clr, synchronised inputs, edge capture, masked irq; PIO_PULSE_EN adds timed pulses.
// Latency: reads combinational, writes land on next clk edge; no backpressure (zero wait states, no waitrequest).
module avalon_pio_ext #(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int unsigned      EDGE_TYPE    = 0,
  parameter int unsigned      PULSE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] A_DATA    = 3'd0;
  localparam logic [2:0] A_INPUT   = 3'd1;
  localparam logic [2:0] A_IRQMASK = 3'd2;
  localparam logic [2:0] A_EDGECAP = 3'd3;
  localparam logic [2:0] A_OUTSET  = 3'd4;
  localparam logic [2:0] A_OUTCLR  = 3'd5;
`ifdef PIO_PULSE_EN
  localparam logic [2:0]  A_PULSE    = 3'd6;
  localparam logic [15:0] PULSE_LOAD = 16'(PULSE_CYCLES);
`endif

  if (WIDTH < 1 || WIDTH > 32 || EDGE_TYPE > 2 || PULSE_CYCLES < 1 || PULSE_CYCLES > 65535) begin : g_param_check
    $error("avalon_pio_ext: parameter out of range");
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] s1_q, s2_q, prev_q;
  logic [1:0]       armed_q, armed_d;
  logic [WIDTH-1:0] det;
  logic             wr;
`ifdef PIO_PULSE_EN
  logic [15:0]      pulse_cnt_q, pulse_cnt_d;
  logic [WIDTH-1:0] pulse_mask_q, pulse_mask_d;
  logic             out_wr;
`endif

  assign wr = chipselect & ~write_n;

  // Saturates at 3 so the stale prev=0 left by reset never pairs with a level already high at release.
  assign armed_d = (armed_q == 2'd3) ? armed_q : armed_q + 2'd1;

  always_comb begin
    det = '0;
    case (EDGE_TYPE)
      0:       det = s2_q & ~prev_q;
      1:       det = ~s2_q & prev_q;
      default: det = s2_q ^ prev_q;
    endcase
    if (armed_q != 2'd3) det = '0;
  end

  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    edge_d = edge_q;
`ifdef PIO_PULSE_EN
    pulse_cnt_d  = pulse_cnt_q;
    pulse_mask_d = pulse_mask_q;
    out_wr       = wr && (address == A_DATA || address == A_OUTSET || address == A_OUTCLR);
    if (pulse_cnt_q != 16'd0) begin
      pulse_cnt_d = pulse_cnt_q - 16'd1;
      if (pulse_cnt_q == 16'd1) begin
        out_d        = out_q & ~pulse_mask_q;
        pulse_mask_d = '0;
      end
    end
`endif
    if (wr) begin
      case (address)
        A_DATA:    out_d  = writedata;
        A_IRQMASK: mask_d = writedata;
        A_EDGECAP: edge_d = edge_q & ~writedata;
        A_OUTSET:  out_d  = out_q | writedata;
        A_OUTCLR:  out_d  = out_q & ~writedata;
`ifdef PIO_PULSE_EN
        A_PULSE: begin
          if (writedata != '0) begin
            out_d        = out_q | writedata;
            pulse_mask_d = pulse_mask_q | writedata;
            pulse_cnt_d  = PULSE_LOAD;
          end
        end
`endif
        default: ;
      endcase
    end
`ifdef PIO_PULSE_EN
    if (out_wr) begin
      pulse_cnt_d  = '0;
      pulse_mask_d = '0;
    end
`endif
    // A fresh edge overrides a same-cycle write-1-clear.
    edge_d = edge_d | det;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= RESET_VALUE;
      mask_q  <= '0;
      edge_q  <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      armed_q <= '0;
`ifdef PIO_PULSE_EN
      pulse_cnt_q  <= '0;
      pulse_mask_q <= '0;
`endif
    end else begin
      out_q   <= out_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      s1_q    <= in_port;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      armed_q <= armed_d;
`ifdef PIO_PULSE_EN
      pulse_cnt_q  <= pulse_cnt_d;
      pulse_mask_q <= pulse_mask_d;
`endif
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:    readdata = out_q;
      A_INPUT:   readdata = s2_q;
      A_IRQMASK: readdata = mask_q;
      A_EDGECAP: readdata = edge_q;
      default:   readdata = '0;
    endcase
  end

  assign out_port = out_q;
  assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_avalon_pio_ext.sv
// Directed vectors for avalon_pio_ext; expectations queued by stimulus, checked by a negedge monitor.
module tb_avalon_pio_ext;

  localparam int K_RD   = 0;
  localparam int K_OUT  = 1;
  localparam int K_IRQ  = 2;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] address;
  logic       chipselect;
  logic       write_n;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic [7:0] in_port;
  logic [7:0] out_port;
  logic       irq;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  avalon_pio_ext #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .PULSE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  // Monitor: every expectation queued during a cycle is checked at that cycle's falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [7:0] got;
      e = sb.pop_front();
      case (e.kind)
        K_RD:    got = readdata;
        K_OUT:   got = out_port;
        default: got = {7'b0, irq};
      endcase
      n_vec++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %02h, expected %02h", e.name, got, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [7:0] e, input string nm);
    exp_t t;
    t.kind = k;
    t.exp  = e;
    t.name = nm;
    sb.push_back(t);
  endtask

  task automatic exp_rd(input logic [2:0] a, input logic [7:0] e, input string nm);
    address = a;
    push(K_RD, e, nm);
  endtask

  task automatic exp_port(input logic [7:0] e, input string nm);
    push(K_OUT, e, nm);
  endtask

  task automatic exp_irq(input logic e, input string nm);
    push(K_IRQ, {7'b0, e}, nm);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;

    // Reset values
    step();
    exp_port(8'hA5, "rst_out"); exp_irq(1'b0, "rst_irq"); exp_rd(3'd0, 8'hA5, "rst_data"); step();
    exp_rd(3'd2, 8'h00, "rst_mask"); step();
    exp_rd(3'd3, 8'h00, "rst_edgecap"); step();
    exp_rd(3'd1, 8'h00, "rst_input"); step();
    reset = 1'b0;
    steps(4);

    // DATA / OUTSET / OUTCLR back to back
    wr(3'd0, 8'h0F); exp_port(8'h0F, "data_0f");
    wr(3'd4, 8'hC0); exp_port(8'hCF, "outset_c0");
    wr(3'd5, 8'h03); exp_port(8'hCC, "outclr_03"); step();
    exp_rd(3'd0, 8'hCC, "data_readback"); step();
    exp_rd(3'd4, 8'h00, "outset_reads_0"); step();
    exp_rd(3'd5, 8'h00, "outclr_reads_0"); step();
`ifndef PIO_PULSE_EN
    wr(3'd6, 8'hFF); exp_port(8'hCC, "addr6_write_ignored"); step();
`endif
    exp_rd(3'd6, 8'h00, "addr6_reads_0"); step();
    wr(3'd7, 8'hFF); exp_rd(3'd7, 8'h00, "addr7_reads_0"); exp_port(8'hCC, "addr7_write_ignored"); step();
    wr(3'd1, 8'hFF); exp_rd(3'd1, 8'h00, "input_write_ignored"); step();

    // Rising edge capture, irq, W1C, falling edge ignored
    wr(3'd2, 8'h01);
    in_port = 8'h01;
    exp_rd(3'd3, 8'h00, "edge_before_sync"); step();
    exp_rd(3'd1, 8'h00, "input_after_1clk"); step();
    exp_rd(3'd1, 8'h01, "input_after_2clk"); exp_irq(1'b0, "irq_before_capture"); step();
    exp_rd(3'd3, 8'h01, "edge_after_3clk"); exp_irq(1'b1, "irq_on_capture"); step();
    wr(3'd3, 8'h01); exp_irq(1'b0, "irq_after_w1c"); exp_rd(3'd3, 8'h00, "edge_w1c"); step();
    in_port = 8'h00;
    steps(4);
    exp_rd(3'd3, 8'h00, "falling_no_capture"); exp_irq(1'b0, "falling_no_irq"); step();

    // Masking
    in_port = 8'h02;
    steps(3);
    exp_rd(3'd3, 8'h02, "edge_bit1"); exp_irq(1'b0, "irq_masked"); step();
    wr(3'd2, 8'h02); exp_irq(1'b1, "irq_unmasked"); step();
    wr(3'd2, 8'h00); exp_irq(1'b0, "irq_mask_cleared"); exp_rd(3'd2, 8'h00, "mask_readback"); step();
    wr(3'd3, 8'hFF); exp_rd(3'd3, 8'h00, "edge_clear_all"); step();

    // Edge coincident with write-1-clear on the same bit
    in_port = 8'h06;
    steps(3);
    exp_rd(3'd3, 8'h04, "edge_bit2"); step();
    in_port = 8'h02;
    steps(3);
    exp_rd(3'd3, 8'h04, "bit2_fall_kept"); step();
    in_port = 8'h06;
    steps(2);
    wr(3'd3, 8'h04); exp_rd(3'd3, 8'h04, "set_wins_over_clear"); step();
    wr(3'd3, 8'h04); exp_rd(3'd3, 8'h00, "w1c_after_race"); step();

`ifdef PIO_PULSE_EN
    // Single pulse: high for exactly 4 cycles
    wr(3'd0, 8'h00);
    wr(3'd6, 8'h10); exp_port(8'h10, "pulse_c0"); step();
    exp_port(8'h10, "pulse_c1"); step();
    exp_port(8'h10, "pulse_c2"); step();
    exp_port(8'h10, "pulse_c3"); step();
    exp_port(8'h00, "pulse_end"); step();
    // Re-trigger at cycle 2 extends to 6 cycles
    wr(3'd6, 8'h10); exp_port(8'h10, "retrig_c0"); step();
    exp_port(8'h10, "retrig_c1");
    wr(3'd6, 8'h10); exp_port(8'h10, "retrig_c2"); step();
    exp_port(8'h10, "retrig_c3"); step();
    exp_port(8'h10, "retrig_c4"); step();
    exp_port(8'h10, "retrig_c5"); step();
    exp_port(8'h00, "retrig_end"); step();
    // DATA write at cycle 2 cancels the pulse
    wr(3'd6, 8'h10); exp_port(8'h10, "cancel_c0"); step();
    exp_port(8'h10, "cancel_c1");
    wr(3'd0, 8'h10);
    steps(3);
    exp_port(8'h10, "cancel_c5"); step();
    exp_port(8'h10, "cancel_c6"); step();
    wr(3'd6, 8'h00); exp_port(8'h10, "pulse_zero_noop"); step();
    steps(5);
    exp_port(8'h10, "pulse_zero_no_clear"); step();
`endif

    // Levels present at reset release never capture
    in_port = 8'hFF;
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    steps(6);
    exp_rd(3'd3, 8'h00, "armed_gate"); step();
    exp_rd(3'd1, 8'hFF, "input_ff"); step();
    wr(3'd2, 8'hFF);
    in_port = 8'h7F;
    steps(3);
    in_port = 8'hFF;
    steps(3);
    exp_rd(3'd3, 8'h80, "capture_after_arm"); exp_irq(1'b1, "irq_after_arm"); step();

    // Asynchronous reset mid-operation
    wr(3'd0, 8'h3C); exp_port(8'h3C, "pre_reset_out"); step();
    reset = 1'b1;
    exp_port(8'hA5, "async_reset_out"); exp_irq(1'b0, "async_reset_irq"); step();
    exp_rd(3'd2, 8'h00, "async_reset_mask"); step();
    exp_rd(3'd3, 8'h00, "async_reset_edge"); step();
    reset = 1'b0;
    steps(2);

    for (int i = 0; i < 10 && sb.size() > 0; i++) step();
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
